// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared select type and output constants for the 1-to-4 demux.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    typedef logic [1:0] demux_sel_t;

    localparam demux_sel_t SEL_Y0 = 2'd0;
    localparam demux_sel_t SEL_Y1 = 2'd1;
    localparam demux_sel_t SEL_Y2 = 2'd2;
    localparam demux_sel_t SEL_Y3 = 2'd3;

    localparam int NUM_OUT = 4;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_if
// Description : Data/select bundle between a word source and the 1-to-4 demux.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
);

    demux_sel_t             sel;
    logic [WIDTH-1:0]       i;
    logic                   in_valid;
    logic [WIDTH-1:0]       y0;
    logic [WIDTH-1:0]       y1;
    logic [WIDTH-1:0]       y2;
    logic [WIDTH-1:0]       y3;
    logic [NUM_OUT-1:0]     y_valid;

    modport master (
        output sel,
        output i,
        output in_valid,
        input  y0,
        input  y1,
        input  y2,
        input  y3,
        input  y_valid
    );

    modport slave (
        input  sel,
        input  i,
        input  in_valid,
        output y0,
        output y1,
        output y2,
        output y3,
        output y_valid
    );

endinterface : demux_if
`default_nettype wire

// File: rtl/demux_sel_decode.sv
`default_nettype none
// ============================================================================
// Module      : demux_sel_decode
// Description : Combinational 2-to-4 one-hot decoder with enable.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_sel_decode
    import demux_pkg::*;
(
    input  wire demux_sel_t         i_sel,
    input  wire logic               i_en,
    output logic [NUM_OUT-1:0]      o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            // An unknown select falls through to all-zero
            case (i_sel)
                SEL_Y0:  o_onehot = 4'b0001;
                SEL_Y1:  o_onehot = 4'b0010;
                SEL_Y2:  o_onehot = 4'b0100;
                SEL_Y3:  o_onehot = 4'b1000;
                default: o_onehot = '0;
            endcase
        end
    end

endmodule : demux_sel_decode
`default_nettype wire

// File: rtl/demux_1to4.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4
// Description : Registered 1-to-4 demultiplexer, one-cycle latency, zeroed
//               non-selected outputs, one-hot output valid.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1to4
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
)
(
    input  wire logic   clk,
    input  wire logic   rst,
    demux_if.slave      bus
);

    logic [NUM_OUT-1:0] w_onehot;
    logic [NUM_OUT-1:0] r_valid;
    logic [WIDTH-1:0]   r_y [NUM_OUT];

    demux_sel_decode u_decode (
        .i_sel    (bus.sel),
        .i_en     (bus.in_valid),
        .o_onehot (w_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_y[k] <= '0;
            end
        end else begin
            r_valid <= w_onehot;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_y[k] <= w_onehot[k] ? bus.i : '0;
            end
        end
    end

    assign bus.y0      = r_y[SEL_Y0];
    assign bus.y1      = r_y[SEL_Y1];
    assign bus.y2      = r_y[SEL_Y2];
    assign bus.y3      = r_y[SEL_Y3];
    assign bus.y_valid = r_valid;

    // A qualified word must carry a known select
    always_ff @(posedge clk) begin
        if (!rst && bus.in_valid) begin
            assert (!$isunknown(bus.sel))
                else $error("demux_1to4: unknown sel while in_valid is high");
        end
    end

endmodule : demux_1to4
`default_nettype wire

// File: tb/tb_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1to4
// Description : Scoreboard bench for demux_1to4 with directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1to4;

    localparam int WIDTH = 8;

    typedef struct {
        int                     due;
        logic [3:0][WIDTH-1:0]  y;
        logic [3:0]             v;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q [$];

    demux_if #(.WIDTH(WIDTH)) bus ();

    demux_1to4 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of stimulus and record what must appear after the next edge
    task automatic drive(input logic r, input logic v, input logic [1:0] s,
                         input logic [WIDTH-1:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        bus.in_valid = v;
        bus.sel      = s;
        bus.i        = d;
        e.due = cyc + 1;
        e.y   = '0;
        e.v   = '0;
        if (!r && v) begin
            e.y[s] = d;
            e.v[s] = 1'b1;
        end
        q.push_back(e);
    endtask

    // Monitor: compare each due expectation and the output invariant
    always @(negedge clk) begin
        exp_t                   e;
        logic [3:0][WIDTH-1:0]  act;
        logic                   inv_ok;
        act = {bus.y3, bus.y2, bus.y1, bus.y0};
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due != cyc || act !== e.y || bus.y_valid !== e.v) begin
                errors++;
                $display("FAIL data cyc=%0d due=%0d: got y=%h v=%b, want y=%h v=%b",
                         cyc, e.due, act, bus.y_valid, e.y, e.v);
            end
            inv_ok = ($countones(bus.y_valid) <= 1);
            for (int k = 0; k < 4; k++) begin
                if (!bus.y_valid[k] && act[k] !== '0) inv_ok = 1'b0;
            end
            checks++;
            if (!inv_ok) begin
                errors++;
                $display("FAIL invariant cyc=%0d: got y=%h v=%b, want one-hot valid and zero unselected",
                         cyc, act, bus.y_valid);
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 2'd2;
        bus.i        = 8'h01;

        // Reset dominates a valid word
        drive(1'b1, 1'b1, 2'd2, 8'h01);
        drive(1'b1, 1'b1, 2'd2, 8'h01);
        drive(1'b0, 1'b1, 2'd2, 8'h01);

        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 2; b++) begin
                drive(1'b0, 1'b1, 2'(s), 8'(b));
            end
        end

        drive(1'b0, 1'b1, 2'd0, 8'hA5);
        drive(1'b0, 1'b1, 2'd3, 8'h3C);
        drive(1'b0, 1'b0, 2'd1, 8'hFF);

        drive(1'b0, 1'b1, 2'd2, 8'h55);
        drive(1'b0, 1'b1, 2'd2, 8'h55);
        drive(1'b1, 1'b1, 2'd2, 8'h55);
        drive(1'b0, 1'b1, 2'd2, 8'h55);
        drive(1'b0, 1'b1, 2'd2, 8'h55);

        for (int n = 0; n < 1000; n++) begin
            drive(($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  8'($urandom));
        end

        drive(1'b0, 1'b0, 2'd0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux_1to4
`default_nettype wire
